// File: rtl/pc_update.sv
// pc_update: architectural PC register and next-PC generator.
// Sequences one instruction fetch at a time with a valid/ready request,
// advances the PC on each committed instruction, and halts on a misaligned
// target.
//
// Optional feature macro: PC_TRACE_EN
//   When defined, a TRACE_DEPTH-entry ring records the pre-update PC of every
//   accepted commit. When undefined, trace_rd_data and trace_count read 0.
//
// Ports
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   pc_src         00 pc+4, 01 pc+imm, 10 (rs1+imm)&~1, 11 csr_pc
//   imm            sign-extended immediate
//   rs1_data       jalr base register value
//   csr_pc         mepc/mtvec from the CSR unit
//   commit         1-cycle pulse: current instruction completed
//   fetch_valid    fetch request valid (registered)
//   fetch_ready    IMEM accepts the request
//   fetch_addr     fetch address (= pc)
//   pc             PC of the instruction in flight (registered)
//   pc_plus4       pc+4, combinational link value
//   misalign       sticky misaligned-target flag (registered)
//   trace_rd_idx   trace entry select, 0 = most recent
//   trace_rd_data  selected trace entry (0 when idx >= trace_count)
//   trace_count    valid trace entries, saturating at TRACE_DEPTH
module pc_update #(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = XLEN'(32'h8000_0000),
    parameter int unsigned     TRACE_DEPTH = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [1:0]                       pc_src,
    input  logic [XLEN-1:0]                  imm,
    input  logic [XLEN-1:0]                  rs1_data,
    input  logic [XLEN-1:0]                  csr_pc,
    input  logic                             commit,
    output logic                             fetch_valid,
    input  logic                             fetch_ready,
    output logic [XLEN-1:0]                  fetch_addr,
    output logic [XLEN-1:0]                  pc,
    output logic [XLEN-1:0]                  pc_plus4,
    output logic                             misalign,
    input  logic [$clog2(TRACE_DEPTH)-1:0]   trace_rd_idx,
    output logic [XLEN-1:0]                  trace_rd_data,
    output logic [$clog2(TRACE_DEPTH):0]     trace_count
);

    localparam int unsigned IDX_W = $clog2(TRACE_DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        EXEC = 2'd2,
        HALT = 2'd3
    } state_t;

    state_t          state;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] jalr_sum;
    logic            next_misaligned;
    logic            commit_acc;

    assign pc_plus4   = pc + XLEN'(4);
    assign fetch_addr = pc;
    assign jalr_sum   = rs1_data + imm;
    assign commit_acc = (state == EXEC) && commit;

    // Next-PC select; all additions wrap modulo 2^XLEN.
    always_comb begin
        next_pc = pc_plus4;
        case (pc_src)
            2'b00:   next_pc = pc_plus4;
            2'b01:   next_pc = pc + imm;
            2'b10:   next_pc = {jalr_sum[XLEN-1:1], 1'b0};
            2'b11:   next_pc = csr_pc;
            default: next_pc = pc_plus4;
        endcase
    end

    assign next_misaligned = |next_pc[1:0];

    // Fetch/commit sequencer; fetch_valid is raised on entry to REQ so it is
    // registered and clears asynchronously with rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            fetch_valid <= 1'b0;
            misalign    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state       <= REQ;
                    fetch_valid <= 1'b1;
                end
                REQ: begin
                    if (fetch_ready) begin
                        state       <= EXEC;
                        fetch_valid <= 1'b0;
                    end
                end
                EXEC: begin
                    if (commit) begin
                        pc <= next_pc;
                        if (next_misaligned) begin
                            state    <= HALT;
                            misalign <= 1'b1;
                        end else begin
                            state       <= REQ;
                            fetch_valid <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    fetch_valid <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    fetch_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef PC_TRACE_EN
    logic [XLEN-1:0]  ring [TRACE_DEPTH];
    logic [IDX_W-1:0] wptr;
    logic [CNT_W-1:0] count;
    logic [IDX_W-1:0] rd_ptr;

    // Ring of pre-update PCs; wptr wraps naturally since depth is a power of 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            count <= '0;
            for (int unsigned i = 0; i < TRACE_DEPTH; i++) begin
                ring[i] <= '0;
            end
        end else if (commit_acc) begin
            ring[wptr] <= pc;
            wptr       <= wptr + IDX_W'(1);
            if (count != CNT_W'(TRACE_DEPTH)) begin
                count <= count + CNT_W'(1);
            end
        end
    end

    // Index 0 is the most recent entry, i.e. the one just behind wptr.
    assign rd_ptr        = wptr - IDX_W'(1) - trace_rd_idx;
    assign trace_rd_data = ({1'b0, trace_rd_idx} >= count) ? '0 : ring[rd_ptr];
    assign trace_count   = count;
`else
    logic unused_trace;

    assign unused_trace  = ^{trace_rd_idx, commit_acc};
    assign trace_rd_data = '0;
    assign trace_count   = '0;
`endif

endmodule

// File: tb/tb_pc_update.sv
module tb_pc_update;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned TD     = 16;
    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk;
    logic        rst;
    logic [1:0]  pc_src;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic [31:0] csr_pc;
    logic        commit;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_addr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misalign;
    logic [3:0]  trace_rd_idx;
    logic [31:0] trace_rd_data;
    logic [4:0]  trace_count;

    pc_update #(
        .XLEN        (XLEN),
        .RESET_PC    (RST_PC),
        .TRACE_DEPTH (TD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_src        (pc_src),
        .imm           (imm),
        .rs1_data      (rs1_data),
        .csr_pc        (csr_pc),
        .commit        (commit),
        .fetch_valid   (fetch_valid),
        .fetch_ready   (fetch_ready),
        .fetch_addr    (fetch_addr),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .misalign      (misalign),
        .trace_rd_idx  (trace_rd_idx),
        .trace_rd_data (trace_rd_data),
        .trace_count   (trace_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state: architectural PC and a newest-first log of committed PCs.
    logic [31:0] mpc;
    logic [31:0] trq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_next(input logic [1:0] src, input logic [31:0] cur,
                                               input logic [31:0] im, input logic [31:0] r1,
                                               input logic [31:0] cp);
        logic [31:0] s;
        case (src)
            2'd0:    return cur + 32'd4;
            2'd1:    return cur + im;
            2'd2:    begin s = r1 + im; return s & 32'hFFFF_FFFE; end
            default: return cp;
        endcase
    endfunction

    task automatic check_trace_idx(input logic [3:0] idx);
        int          cnt;
        logic [31:0] exp;
        trace_rd_idx = idx;
        #1;
`ifdef PC_TRACE_EN
        cnt = (trq.size() > TD) ? TD : trq.size();
        exp = (int'(idx) < cnt) ? trq[idx] : 32'd0;
`else
        cnt = 0;
        exp = 32'd0;
`endif
        check("trace_count", 32'(trace_count), 32'(cnt));
        check("trace_data", trace_rd_data, exp);
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        fetch_ready = 1'b0;
        commit      = 1'b0;
        #1;
        check("rst_valid", 32'(fetch_valid), 32'd0);
        check("rst_misalign", 32'(misalign), 32'd0);
        check("rst_pc", pc, RST_PC);
        check("rst_tcount", 32'(trace_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mpc = RST_PC;
        trq.delete();
        @(negedge clk);
    endtask

    // One instruction: REQ (with stalls), EXEC (with waits), then commit.
    task automatic run_instr(input logic [1:0] src, input logic [31:0] imm_v,
                             input logic [31:0] rs1_v, input logic [31:0] csr_v,
                             input int stalls, input int waits, output bit halted);
        logic [31:0] nxt;
        check("req_valid", 32'(fetch_valid), 32'd1);
        check("req_addr", fetch_addr, mpc);
        check("req_misalign", 32'(misalign), 32'd0);
        for (int k = 0; k < stalls; k++) begin
            fetch_ready = 1'b0;
            commit      = 1'($urandom);
            pc_src      = 2'($urandom);
            imm         = $urandom;
            rs1_data    = $urandom;
            csr_pc      = $urandom;
            @(negedge clk);
            commit = 1'b0;
            check("stall_valid", 32'(fetch_valid), 32'd1);
            check("stall_addr", fetch_addr, mpc);
        end
        fetch_ready = 1'b1;
        commit      = 1'b0;
        @(negedge clk);
        fetch_ready = 1'b0;
        check("exec_valid", 32'(fetch_valid), 32'd0);
        check("exec_pc", pc, mpc);
        for (int k = 0; k < waits; k++) begin
            pc_src = 2'($urandom);
            @(negedge clk);
            check("wait_pc", pc, mpc);
            check_trace_idx(4'($urandom_range(0, 15)));
        end
        pc_src   = src;
        imm      = imm_v;
        rs1_data = rs1_v;
        csr_pc   = csr_v;
        commit   = 1'b1;
        #1;
        check("pc_plus4", pc_plus4, mpc + 32'd4);
        nxt = model_next(src, mpc, imm_v, rs1_v, csr_v);
        @(negedge clk);
        commit = 1'b0;
        trq.push_front(mpc);
        if (trq.size() > TD) void'(trq.pop_back());
        mpc    = nxt;
        halted = (nxt[1:0] != 2'b00);
        check("commit_pc", pc, mpc);
        if (halted) begin
            check("halt_misalign", 32'(misalign), 32'd1);
            for (int k = 0; k < 3; k++) begin
                fetch_ready = 1'b1;
                commit      = 1'b1;
                @(negedge clk);
                check("halt_valid", 32'(fetch_valid), 32'd0);
                check("halt_pc", pc, mpc);
            end
            fetch_ready = 1'b0;
            commit      = 1'b0;
            check_trace_idx(4'd0);
        end
    endtask

    function automatic logic [31:0] rand_aligned();
        logic [31:0] v;
        v = $urandom;
        if ($urandom_range(0, 7) != 0) v[1:0] = 2'b00;
        return v;
    endfunction

    bit h;

    initial begin
        rst = 1'b1; pc_src = '0; imm = '0; rs1_data = '0; csr_pc = '0;
        commit = 1'b0; fetch_ready = 1'b0; trace_rd_idx = '0;
        do_reset();

        // Sequential fetch from RESET_PC.
        for (int i = 0; i < 4; i++) begin
            check("seq_addr", fetch_addr, RST_PC + 32'(4 * i));
            run_instr(2'd0, 32'd0, 32'd0, 32'd0, 0, 0, h);
        end
        check("seq_pc10", fetch_addr, 32'h8000_0010);

        // Relative and register-indirect targets.
        run_instr(2'd1, 32'hFFFF_FFF0, 32'd0, 32'd0, 0, 1, h);
        check("rel_addr", fetch_addr, 32'h8000_0000);
        run_instr(2'd2, 32'd3, 32'h8000_0101, 32'd0, 0, 0, h);
        check("jalr_addr", fetch_addr, 32'h8000_0104);

        // Long stall in REQ with stray commit pulses.
        run_instr(2'd0, 32'd0, 32'd0, 32'd0, 5, 0, h);
        check("stall_next", fetch_addr, 32'h8000_0108);

        // Wraparound of pc+4.
        run_instr(2'd3, 32'd0, 32'd0, 32'hFFFF_FFFC, 0, 0, h);
        run_instr(2'd0, 32'd0, 32'd0, 32'd0, 0, 0, h);
        check("wrap_addr", fetch_addr, 32'd0);

        // Misaligned CSR target halts until reset.
        run_instr(2'd3, 32'd0, 32'd0, 32'h8000_0102, 0, 0, h);
        check("halt_flag", 32'(h), 32'd1);
        check("halt_target", pc, 32'h8000_0102);
        do_reset();

        // Reset asserted mid-request drops fetch_valid before the next edge.
        fetch_ready = 1'b0;
        @(negedge clk);
        check("midreq_valid", 32'(fetch_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midreq_drop", 32'(fetch_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mpc = RST_PC;
        trq.delete();
        @(negedge clk);
        check("restart_addr", fetch_addr, RST_PC);

        // Twenty sequential commits fill and wrap the trace ring.
        for (int i = 0; i < 20; i++) run_instr(2'd0, 32'd0, 32'd0, 32'd0, 0, 0, h);
        trace_rd_idx = 4'd0;
        #1;
`ifdef PC_TRACE_EN
        check("t6_count", 32'(trace_count), 32'd16);
        check("t6_idx0", trace_rd_data, 32'h8000_004C);
        trace_rd_idx = 4'd15;
        #1;
        check("t6_idx15", trace_rd_data, 32'h8000_0010);
`else
        check("t6_count", 32'(trace_count), 32'd0);
        check("t6_idx0", trace_rd_data, 32'd0);
        trace_rd_idx = 4'd15;
        #1;
        check("t6_idx15", trace_rd_data, 32'd0);
`endif

        // Randomized instruction stream.
        for (int i = 0; i < 150; i++) begin
            run_instr(2'($urandom), rand_aligned(), rand_aligned(), rand_aligned(),
                      $urandom_range(0, 3), $urandom_range(0, 2), h);
            if (h) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
